// File: rtl/intra_4x4_recon.sv
// intra_4x4_recon: decoder-side 4x4 luma intra PE (DC prediction, dequant, inverse transform, clip).
// Define INTRA_RECON_CLIPCNT_EN to add the per-block clipped-pixel counter on clip_cnt_o.
//
// state | meaning
// IDLE  | ready for a block, capture levels/neighbours/qp on in_valid
// PRED  | DC predictor from the captured neighbours
// DEQ   | levels scaled in place in blk
// IROW  | horizontal inverse transform in place
// ICOL  | vertical inverse transform, rounded down to residual
// RECON | pred + residual, clip, load recon_o
// OUT   | hold result until out_ready
module intra_4x4_recon #(
  parameter int QP_DEFAULT = 27,
  parameter int CW         = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 h264_reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [CW-1:0] coeff_i [4][4],
  input  logic [5:0]           qp_i,
  input  logic [7:0]           A,
  input  logic [7:0]           B,
  input  logic [7:0]           C,
  input  logic [7:0]           D,
  input  logic [7:0]           I,
  input  logic [7:0]           J,
  input  logic [7:0]           K,
  input  logic [7:0]           L,
  input  logic                 mbAddrA_valid,
  input  logic                 mbAddrB_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           recon_o [4][4]
`ifdef INTRA_RECON_CLIPCNT_EN
  ,
  output logic [4:0]           clip_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRED, S_DEQ, S_IROW, S_ICOL, S_RECON, S_OUT
  } state_t;

  state_t             state_q, state_d;
  logic signed [31:0] blk_q [4][4];
  logic signed [31:0] blk_d [4][4];
  logic [7:0]         top_q [4];
  logic [7:0]         top_d [4];
  logic [7:0]         left_q [4];
  logic [7:0]         left_d [4];
  logic               top_ok_q, top_ok_d, left_ok_q, left_ok_d;
  logic [5:0]         qp_q, qp_d;
  logic [7:0]         pred_q, pred_d;
  logic [7:0]         recon_q [4][4];
  logic [7:0]         recon_d [4][4];
  logic               out_valid_q, out_valid_d;

  logic [10:0]        sum_top, sum_left;
  logic [5:0]         qp_div, qp_mod;
  logic [1:0]         cls;
  logic signed [31:0] t_e, t_f, t_g, t_h, t_s;

`ifdef INTRA_RECON_CLIPCNT_EN
  logic [4:0]         clip_cnt_q, clip_cnt_d, nclip;
`endif

  // qp_i is sampled on every block; the default is kept only as documentation of the encoder setting.
  logic [31:0] unused_qp_default;
  assign unused_qp_default = QP_DEFAULT;

  function automatic logic [4:0] vscale(input logic [5:0] m, input logic [1:0] c);
    logic [14:0] row;
    case (m)
      6'd0:    row = {5'd10, 5'd16, 5'd13};
      6'd1:    row = {5'd11, 5'd18, 5'd14};
      6'd2:    row = {5'd13, 5'd20, 5'd16};
      6'd3:    row = {5'd14, 5'd23, 5'd18};
      6'd4:    row = {5'd16, 5'd25, 5'd20};
      default: row = {5'd18, 5'd29, 5'd23};
    endcase
    case (c)
      2'd0:    vscale = row[14:10];
      2'd1:    vscale = row[9:5];
      default: vscale = row[4:0];
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    top_d       = top_q;
    left_d      = left_q;
    top_ok_d    = top_ok_q;
    left_ok_d   = left_ok_q;
    qp_d        = qp_q;
    pred_d      = pred_q;
    recon_d     = recon_q;
    out_valid_d = out_valid_q;
    cls         = 2'd0;
    t_e         = '0;
    t_f         = '0;
    t_g         = '0;
    t_h         = '0;
    t_s         = '0;
`ifdef INTRA_RECON_CLIPCNT_EN
    clip_cnt_d  = clip_cnt_q;
    nclip       = 5'd0;
`endif
    sum_top  = {3'b0, top_q[0]} + {3'b0, top_q[1]} + {3'b0, top_q[2]} + {3'b0, top_q[3]};
    sum_left = {3'b0, left_q[0]} + {3'b0, left_q[1]} + {3'b0, left_q[2]} + {3'b0, left_q[3]};
    qp_div   = qp_q / 6'd6;
    qp_mod   = qp_q % 6'd6;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
              blk_d[r][c] = 32'(coeff_i[r][c]);
          qp_d      = (qp_i > 6'd51) ? 6'd51 : qp_i;
          top_d     = '{A, B, C, D};
          left_d    = '{I, J, K, L};
          top_ok_d  = mbAddrB_valid;
          left_ok_d = mbAddrA_valid;
          state_d   = S_PRED;
        end
      end
      S_PRED: begin
        case ({top_ok_q, left_ok_q})
          2'b10:   pred_d = 8'((sum_top + 11'd2) >> 2);
          2'b01:   pred_d = 8'((sum_left + 11'd2) >> 2);
          2'b11:   pred_d = 8'((sum_top + sum_left + 11'd4) >> 3);
          default: pred_d = 8'd128;
        endcase
        state_d = S_DEQ;
      end
      S_DEQ: begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            cls = ((r % 2 == 0) && (c % 2 == 0)) ? 2'd0 :
                  ((r % 2 == 1) && (c % 2 == 1)) ? 2'd1 : 2'd2;
            blk_d[r][c] = (blk_q[r][c] * $signed({27'd0, vscale(qp_mod, cls)})) <<< qp_div;
          end
        end
        state_d = S_IROW;
      end
      S_IROW: begin
        for (int r = 0; r < 4; r++) begin
          t_e = blk_q[r][0] + blk_q[r][2];
          t_f = blk_q[r][0] - blk_q[r][2];
          t_g = (blk_q[r][1] >>> 1) - blk_q[r][3];
          t_h = blk_q[r][1] + (blk_q[r][3] >>> 1);
          blk_d[r][0] = t_e + t_h;
          blk_d[r][1] = t_f + t_g;
          blk_d[r][2] = t_f - t_g;
          blk_d[r][3] = t_e - t_h;
        end
        state_d = S_ICOL;
      end
      S_ICOL: begin
        // Final rounding folded into the column pass so blk holds the residual for RECON.
        for (int c = 0; c < 4; c++) begin
          t_e = blk_q[0][c] + blk_q[2][c];
          t_f = blk_q[0][c] - blk_q[2][c];
          t_g = (blk_q[1][c] >>> 1) - blk_q[3][c];
          t_h = blk_q[1][c] + (blk_q[3][c] >>> 1);
          blk_d[0][c] = (t_e + t_h + 32'sd32) >>> 6;
          blk_d[1][c] = (t_f + t_g + 32'sd32) >>> 6;
          blk_d[2][c] = (t_f - t_g + 32'sd32) >>> 6;
          blk_d[3][c] = (t_e - t_h + 32'sd32) >>> 6;
        end
        state_d = S_RECON;
      end
      S_RECON: begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            t_s = $signed({24'd0, pred_q}) + blk_q[r][c];
            if (t_s < 32'sd0) begin
              recon_d[r][c] = 8'd0;
`ifdef INTRA_RECON_CLIPCNT_EN
              nclip = nclip + 5'd1;
`endif
            end else if (t_s > 32'sd255) begin
              recon_d[r][c] = 8'd255;
`ifdef INTRA_RECON_CLIPCNT_EN
              nclip = nclip + 5'd1;
`endif
            end else begin
              recon_d[r][c] = t_s[7:0];
            end
          end
        end
`ifdef INTRA_RECON_CLIPCNT_EN
        clip_cnt_d = nclip;
`endif
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (h264_reset) begin
      state_d     = S_IDLE;
      top_ok_d    = 1'b0;
      left_ok_d   = 1'b0;
      qp_d        = 6'd0;
      pred_d      = 8'd0;
      out_valid_d = 1'b0;
      for (int r = 0; r < 4; r++) begin
        top_d[r]  = 8'd0;
        left_d[r] = 8'd0;
        for (int c = 0; c < 4; c++) begin
          blk_d[r][c]   = '0;
          recon_d[r][c] = 8'd0;
        end
      end
`ifdef INTRA_RECON_CLIPCNT_EN
      clip_cnt_d = 5'd0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      top_ok_q    <= 1'b0;
      left_ok_q   <= 1'b0;
      qp_q        <= 6'd0;
      pred_q      <= 8'd0;
      out_valid_q <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        top_q[r]  <= 8'd0;
        left_q[r] <= 8'd0;
        for (int c = 0; c < 4; c++) begin
          blk_q[r][c]   <= '0;
          recon_q[r][c] <= 8'd0;
        end
      end
`ifdef INTRA_RECON_CLIPCNT_EN
      clip_cnt_q <= 5'd0;
`endif
    end else begin
      state_q     <= state_d;
      top_ok_q    <= top_ok_d;
      left_ok_q   <= left_ok_d;
      qp_q        <= qp_d;
      pred_q      <= pred_d;
      out_valid_q <= out_valid_d;
      top_q       <= top_d;
      left_q      <= left_d;
      blk_q       <= blk_d;
      recon_q     <= recon_d;
`ifdef INTRA_RECON_CLIPCNT_EN
      clip_cnt_q <= clip_cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign recon_o   = recon_q;
`ifdef INTRA_RECON_CLIPCNT_EN
  assign clip_cnt_o = clip_cnt_q;
`endif

endmodule

// File: tb/tb_intra_4x4_recon.sv
// Bench for intra_4x4_recon: reference model feeds a scoreboard queue, popped when out_valid rises.
module tb_intra_4x4_recon;

  logic               clk = 1'b0;
  logic               rst, h264_reset, in_valid, in_ready, out_valid, out_ready;
  logic signed [14:0] coeff_i [4][4];
  logic [5:0]         qp_i;
  logic [7:0]         nb_top [4];
  logic [7:0]         nb_left [4];
  logic               mb_a, mb_b;
  logic [7:0]         recon_o [4][4];
`ifdef INTRA_RECON_CLIPCNT_EN
  logic [4:0]         clip_cnt_o;
`endif

  int           cf [4][4];
  int           qp_v;
  bit           left_v, top_v;
  logic [127:0] exp_q [$];
  logic [4:0]   clip_q [$];
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  intra_4x4_recon dut (
    .clk(clk), .rst(rst), .h264_reset(h264_reset),
    .in_valid(in_valid), .in_ready(in_ready), .coeff_i(coeff_i), .qp_i(qp_i),
    .A(nb_top[0]), .B(nb_top[1]), .C(nb_top[2]), .D(nb_top[3]),
    .I(nb_left[0]), .J(nb_left[1]), .K(nb_left[2]), .L(nb_left[3]),
    .mbAddrA_valid(mb_a), .mbAddrB_valid(mb_b),
    .out_valid(out_valid), .out_ready(out_ready), .recon_o(recon_o)
`ifdef INTRA_RECON_CLIPCNT_EN
    , .clip_cnt_o(clip_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] flat_recon();
    logic [127:0] f;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        f[(r*4+c)*8 +: 8] = recon_o[r][c];
    return f;
  endfunction

  function automatic logic [127:0] rep16(input int v);
    logic [127:0] f;
    for (int k = 0; k < 16; k++) f[k*8 +: 8] = 8'(v);
    return f;
  endfunction

  function automatic int vtab(input int m, input int cls);
    int v0 [6] = '{10, 11, 13, 14, 16, 18};
    int v1 [6] = '{16, 18, 20, 23, 25, 29};
    int v2 [6] = '{13, 14, 16, 18, 20, 23};
    if (cls == 0) return v0[m];
    if (cls == 1) return v1[m];
    return v2[m];
  endfunction

  function automatic void idct4(input int i0, input int i1, input int i2, input int i3,
                                output int o0, output int o1, output int o2, output int o3);
    int e, f, g, h;
    e = i0 + i2;
    f = i0 - i2;
    g = (i1 >>> 1) - i3;
    h = i1 + (i3 >>> 1);
    o0 = e + h;
    o1 = f + g;
    o2 = f - g;
    o3 = e - h;
  endfunction

  function automatic logic [127:0] model(output logic [4:0] ncl);
    int q, p, cls, x, st, sl;
    int d [4][4];
    int t [4][4];
    int res [4][4];
    logic [127:0] blk;
    q  = (qp_v > 51) ? 51 : qp_v;
    st = nb_top[0] + nb_top[1] + nb_top[2] + nb_top[3];
    sl = nb_left[0] + nb_left[1] + nb_left[2] + nb_left[3];
    if (top_v && left_v) p = (st + sl + 4) / 8;
    else if (top_v)      p = (st + 2) / 4;
    else if (left_v)     p = (sl + 2) / 4;
    else                 p = 128;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        cls = (r % 2 == 0 && c % 2 == 0) ? 0 : ((r % 2 == 1 && c % 2 == 1) ? 1 : 2);
        d[r][c] = cf[r][c] * vtab(q % 6, cls) * (1 << (q / 6));
      end
    for (int r = 0; r < 4; r++)
      idct4(d[r][0], d[r][1], d[r][2], d[r][3], t[r][0], t[r][1], t[r][2], t[r][3]);
    for (int c = 0; c < 4; c++)
      idct4(t[0][c], t[1][c], t[2][c], t[3][c], res[0][c], res[1][c], res[2][c], res[3][c]);
    ncl = 5'd0;
    blk = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        x = p + ((res[r][c] + 32) >>> 6);
        if (x < 0) begin
          x = 0;
          ncl++;
        end else if (x > 255) begin
          x = 255;
          ncl++;
        end
        blk[(r*4+c)*8 +: 8] = 8'(x);
      end
    return blk;
  endfunction

  task automatic drive();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        coeff_i[r][c] = cf[r][c][14:0];
    qp_i = qp_v[5:0];
    mb_a = left_v;
    mb_b = top_v;
  endtask

  task automatic set_blk(input int c00, input int qp, input bit lv, input bit tv);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        cf[r][c] = 0;
    cf[0][0] = c00;
    qp_v     = qp;
    left_v   = lv;
    top_v    = tv;
  endtask

  task automatic set_nb(input int t, input int l);
    for (int k = 0; k < 4; k++) begin
      nb_top[k]  = 8'(t);
      nb_left[k] = 8'(l);
    end
  endtask

  task automatic push_exp();
    logic [4:0] n;
    exp_q.push_back(model(n));
    clip_q.push_back(n);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_block(input string tag, input int exp_pix);
    int lat;
    logic [127:0] e;
    logic [4:0] ec;
    drive();
    push_exp();
    in_valid = 1'b1;
    chk({tag, "_rdy"}, 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat = k;
    end
    chk({tag, "_lat"}, 128'(lat), 128'd5);
    e  = exp_q.pop_front();
    ec = clip_q.pop_front();
    if (lat != 0) begin
      chk({tag, "_busy"}, 128'(in_ready), 128'd0);
      chk({tag, "_pix"}, flat_recon(), e);
      if (exp_pix >= 0) chk({tag, "_const"}, flat_recon(), rep16(exp_pix));
`ifdef INTRA_RECON_CLIPCNT_EN
      chk({tag, "_clip"}, 128'(clip_cnt_o), 128'(ec));
`endif
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_drop"}, 128'({out_valid, in_ready}), 128'b01);
      chk({tag, "_keep"}, flat_recon(), e);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] e;
    logic [4:0]   ec;
    int           lat;
    rst = 1'b0; h264_reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_blk(0, 27, 1'b0, 1'b0);
    set_nb(0, 0);
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hs", 128'({in_ready, out_valid}), 128'b10);
    chk("reset_pix", flat_recon(), '0);
`ifdef INTRA_RECON_CLIPCNT_EN
    chk("reset_clip", 128'(clip_cnt_o), 128'd0);
`endif
    rst = 1'b1;
    @(negedge clk);

    set_blk(0, 27, 1'b0, 1'b0); set_nb(77, 99);
    run_block("zero_none", 128);
    set_blk(0, 27, 1'b1, 1'b1); set_nb(100, 200);
    run_block("zero_both", 150);
    set_blk(0, 27, 1'b1, 1'b0); set_nb(255, 0);
    nb_left = '{8'd10, 8'd11, 8'd12, 8'd13};
    run_block("left_only", 12);
    set_blk(0, 20, 1'b0, 1'b1); set_nb(0, 250);
    nb_top = '{8'd1, 8'd2, 8'd3, 8'd5};
    run_block("top_only", 3);
    set_blk(1, 27, 1'b0, 1'b0); set_nb(0, 0);
    run_block("dc_pos", 132);
    set_blk(-100, 27, 1'b0, 1'b0);
    run_block("dc_neg", 0);
    set_blk(1, 63, 1'b0, 1'b0);
    run_block("qp_sat", 184);
    set_blk(0, 30, 1'b1, 1'b1); set_nb(250, 250);
    cf[0][0] = 40; cf[1][2] = -7; cf[3][3] = 5; cf[2][1] = 3;
    run_block("mixed_hi", -1);

    // Output back-pressure with in_valid held high, then soft reset mid-ICOL on the next block.
    set_blk(-100, 27, 1'b0, 1'b0); set_nb(0, 0);
    drive();
    push_exp();
    in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat = k;
    end
    chk("hold_lat", 128'(lat), 128'd5);
    e  = exp_q.pop_front();
    ec = clip_q.pop_front();
`ifdef INTRA_RECON_CLIPCNT_EN
    chk("hold_clip", 128'(clip_cnt_o), 128'd16);
`endif
    set_blk(1, 27, 1'b0, 1'b0);
    drive();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_pix", flat_recon(), e);
      chk("hold_hs", 128'({out_valid, in_ready}), 128'b10);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hold_rel", 128'({out_valid, in_ready}), 128'b01);
    @(posedge clk);
    #1;
    chk("next_acc", 128'(in_ready), 128'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid   = 1'b0;
    h264_reset = 1'b1;
    @(posedge clk);
    #1;
    chk("sreset_hs", 128'({out_valid, in_ready}), 128'b01);
    chk("sreset_pix", flat_recon(), '0);
`ifdef INTRA_RECON_CLIPCNT_EN
    chk("sreset_clip", 128'(clip_cnt_o), 128'd0);
`endif
    @(negedge clk);
    h264_reset = 1'b0;
    @(negedge clk);

    set_blk(0, 27, 1'b1, 1'b0); set_nb(0, 60);
    run_block("after_rst", 60);

    for (int n = 0; n < 8; n++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          cf[r][c] = int'($urandom_range(40)) - 20;
      qp_v   = int'($urandom_range(63));
      left_v = 1'($urandom_range(1));
      top_v  = 1'($urandom_range(1));
      for (int k = 0; k < 4; k++) begin
        nb_top[k]  = 8'($urandom_range(255));
        nb_left[k] = 8'($urandom_range(255));
      end
      run_block($sformatf("rand%0d", n), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
